// File: rtl/cla_pkg.sv
// Shared constants and types for the registered carry-lookahead adder.
package cla_pkg;

  localparam int CLA_GROUP     = 4;
  localparam int CLA_DEF_WIDTH = 4;

  // Per-group propagate/generate/carry bundle for one 4-bit slice.
  typedef struct packed {
    logic [CLA_GROUP-1:0] p;
    logic [CLA_GROUP-1:0] g;
    logic [CLA_GROUP-1:0] c;
  } cla_grp_t;

  function automatic logic [2*CLA_GROUP-1:0] cla_pg(input logic [CLA_GROUP-1:0] a,
                                                    input logic [CLA_GROUP-1:0] b);
    return {a ^ b, a & b};
  endfunction

endpackage

// File: rtl/cla_block4.sv
// 4-bit carry-lookahead unit: flattened per-bit carries plus group generate/propagate.
module cla_block4
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gg,
  output logic       gp
);

  cla_grp_t grp;

  always_comb begin
    {grp.p, grp.g} = cla_pg(a, b);
    // Each carry is a two-level expression of g/p/cin; nothing ripples.
    grp.c[0] = cin;
    grp.c[1] = grp.g[0] | (grp.p[0] & cin);
    grp.c[2] = grp.g[1] | (grp.p[1] & grp.g[0]) | (grp.p[1] & grp.p[0] & cin);
    grp.c[3] = grp.g[2] | (grp.p[2] & grp.g[1]) | (grp.p[2] & grp.p[1] & grp.g[0])
             | (grp.p[2] & grp.p[1] & grp.p[0] & cin);
  end

  assign sum = grp.p ^ grp.c;
  assign gg  = grp.g[3] | (grp.p[3] & grp.g[2]) | (grp.p[3] & grp.p[2] & grp.g[1])
             | (grp.p[3] & grp.p[2] & grp.p[1] & grp.g[0]);
  assign gp  = &grp.p;

endmodule

// File: rtl/cla_adder.sv
// Registered unsigned carry-lookahead adder, 1-cycle latency.
// Define CLA_IN_REG_EN to add an input register stage (2-cycle latency).
module cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
);

  localparam int NG = WIDTH / CLA_GROUP;

  if ((WIDTH < CLA_GROUP) || (WIDTH % CLA_GROUP != 0)) begin : g_width_chk
    $error("cla_adder: WIDTH must be a non-zero multiple of 4");
  end

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             vld_p0;

`ifdef CLA_IN_REG_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             vld_in_q;

  // Stage p0: operand capture. Operands load only when valid so idle X never enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      vld_in_q <= 1'b0;
    end else begin
      vld_in_q <= in_valid;
      if (in_valid) begin
        a_q <= A;
        b_q <= B;
      end
    end
  end

  assign a_p0   = a_q;
  assign b_p0   = b_q;
  assign vld_p0 = vld_in_q;
`else
  assign a_p0   = A;
  assign b_p0   = B;
  assign vld_p0 = in_valid;
`endif

  logic             cin0;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             vld_q;

  assign cin0 = 1'b0;

  for (genvar k = 0; k < NG; k++) begin : g_blk
    cla_block4 u_blk (
      .a   (a_p0[CLA_GROUP*k +: CLA_GROUP]),
      .b   (b_p0[CLA_GROUP*k +: CLA_GROUP]),
      .cin (gc[k]),
      .sum (s_d[CLA_GROUP*k +: CLA_GROUP]),
      .gg  (gg[k]),
      .gp  (gp[k])
    );
  end

  // Second-level lookahead: gc[k] = OR_j (GG[j] & GP[j+1..k-1]) | (GP[0..k-1] & cin0).
  always_comb begin
    logic term;
    logic all_p;
    gc    = '0;
    term  = 1'b0;
    all_p = 1'b0;
    gc[0] = cin0;
    for (int k = 1; k <= NG; k++) begin
      all_p = cin0;
      for (int m = 0; m < k; m++) all_p = all_p & gp[m];
      gc[k] = all_p;
      for (int j = 0; j < k; j++) begin
        term = gg[j];
        for (int m = j + 1; m < k; m++) term = term & gp[m];
        gc[k] = gc[k] | term;
      end
    end
  end

  // Stage p1: result registers; sum/carry hold when no valid operands arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= vld_p0;
      if (vld_p0) begin
        s_q    <= s_d;
        cout_q <= gc[NG];
      end
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_cla_adder.sv
// Directed and exhaustive check of cla_adder (4-bit), latency follows CLA_IN_REG_EN.
module tb_cla_adder;

`ifdef CLA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       in_valid = 1'b0;
  logic [3:0] s;
  logic       cout;
  logic       out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Directed ops: a, b, valid, expected s, expected cout (hold entries repeat the last result).
  localparam int NV = 10;
  int ta [NV] = '{'h0, 'hF, 'h7, 'hF, 'h5, 'h3, 'h9, 'hC, 0, 0};
  int tb [NV] = '{'h0, 'h1, 'h8, 'hF, 'h3, 'h4, 'h9, 'h5, 0, 0};
  int tv [NV] = '{1,   1,   1,   1,   1,   1,   1,   1,   0, 0};
  int es [NV] = '{'h0, 'h0, 'hF, 'hE, 'h8, 'h7, 'h2, 'h1, 'h1, 'h1};
  int ec [NV] = '{0,   1,   0,   1,   0,   0,   1,   1,   1, 1};

  always #5 clk = ~clk;

  cla_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    A        = 4'bxxxx;
    B        = 4'bxxxx;
  endtask

  initial begin
    // Asynchronous reset with no clock edge involved.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_vld", out_valid, 0);
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      chk("post_rst_vld", out_valid, 0);
      chk("post_rst_s", {cout, s}, 0);
    end

    // Directed table, back-to-back; at negedge i the outputs belong to op i-LAT.
    for (int i = 0; i < NV + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        chk($sformatf("dir%0d_vld", i - LAT), out_valid, tv[i-LAT]);
        chk($sformatf("dir%0d_s", i - LAT), s, es[i-LAT]);
        chk($sformatf("dir%0d_cout", i - LAT), cout, ec[i-LAT]);
      end
      if (i < NV && tv[i] != 0) begin
        in_valid = 1'b1;
        A        = 4'(ta[i]);
        B        = 4'(tb[i]);
      end else begin
        drive_idle();
      end
    end

    // Reset asserted while a result is in flight: it must be discarded.
    @(negedge clk);
    in_valid = 1'b1;
    A        = 4'hF;
    B        = 4'hF;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_s", s, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_vld", out_valid, 0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      chk("midrst_hold_vld", out_valid, 0);
      chk("midrst_hold_sc", {cout, s}, 0);
    end

    // Exhaustive sweep against a behavioural model.
    for (int k = 0; k < 256 + LAT; k++) begin
      @(negedge clk);
      if (k >= LAT) begin
        int j;
        int r;
        j = k - LAT;
        r = (j >> 4) + (j & 15);
        chk($sformatf("sw_%0d+%0d_vld", j >> 4, j & 15), out_valid, 1);
        chk($sformatf("sw_%0d+%0d_s", j >> 4, j & 15), s, r & 15);
        chk($sformatf("sw_%0d+%0d_cout", j >> 4, j & 15), cout, (r >> 4) & 1);
      end
      if (k < 256) begin
        in_valid = 1'b1;
        A        = 4'(k >> 4);
        B        = 4'(k & 15);
      end else begin
        drive_idle();
      end
    end
    @(negedge clk);
    chk("sw_end_vld", out_valid, 0);
    chk("sw_end_hold", {cout, s}, 5'h1E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
